wallace_mul_pipe: RTL and testbench



---
 rtl/wallace_mul_pipe.sv | 156 +++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier, signed/unsigned per beat, tag sideband.
// Global-stall flow control; carry-save pair resolved by a registered final adder.
module wallace_mul_pipe #(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int P = 2 * WIDTH;

    function automatic int calc_levels(int w);
        int n;
        n = 0;
        for (int d = 2; d < w; d = d + d / 2) n++;
        return n;
    endfunction

    function automatic int rows_at(int l);
        int n;
        n = WIDTH;
        for (int k = 0; k < l; k++) n = n - n / 3;
        return n;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic               s0_v;
    logic               s0_sg;
    logic [WIDTH-1:0]   s0_a;
    logic [WIDTH-1:0]   s0_b;
    logic [TAG_W-1:0]   s0_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v <= 1'b0;
        end else if (adv) begin
            s0_v   <= in_valid;
            s0_sg  <= in_signed;
            s0_a   <= in_a;
            s0_b   <= in_b;
            s0_tag <= in_tag;
        end
    end

    // Baugh-Wooley: the two correction constants fit in unused bits of rows 0 and WIDTH-1
    logic [WIDTH-1:0][P-1:0] pp;
    logic [WIDTH-1:0]        pp_t;

    always_comb begin
        pp   = '0;
        pp_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp_t = s0_a & {WIDTH{s0_b[i]}};
            if (s0_sg) begin
                if (i < WIDTH - 1) pp_t[WIDTH-1] = ~pp_t[WIDTH-1];
                else pp_t[WIDTH-2:0] = ~pp_t[WIDTH-2:0];
            end
            pp[i] = {{WIDTH{1'b0}}, pp_t} << i;
        end
        if (s0_sg) begin
            pp[0][WIDTH]       = 1'b1;
            pp[WIDTH-1][P-1]   = 1'b1;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int  N   = rows_at(l);
        localparam int  NN  = rows_at(l + 1);
        localparam int  G   = N / 3;
        localparam bit  REG = ((l + 1) % LVL_PER_STG == 0) || (l + 1 == LEVELS);

        logic [N-1:0][P-1:0]  cur;
        logic                 cv;
        logic [TAG_W-1:0]     ct;
        logic [NN-1:0][P-1:0] red;
        logic [NN-1:0][P-1:0] nxt;
        logic                 nv;
        logic [TAG_W-1:0]     nt;

        if (l == 0) begin : g_src
            assign cur = pp;
            assign cv  = s0_v;
            assign ct  = s0_tag;
        end else begin : g_src
            assign cur = g_lvl[l-1].nxt;
            assign cv  = g_lvl[l-1].nv;
            assign ct  = g_lvl[l-1].nt;
        end

        always_comb begin
            red = '0;
            for (int g = 0; g < G; g++) begin
                red[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                red[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                              (cur[3*g] & cur[3*g+2]) |
                              (cur[3*g+1] & cur[3*g+2])) << 1;
            end
            for (int k = 3 * G; k < N; k++) red[k-G] = cur[k];
        end

        if (REG) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    nv <= 1'b0;
                end else if (adv) begin
                    nv  <= cv;
                    nxt <= red;
                    nt  <= ct;
                end
            end
        end else begin : g_pass
            assign nxt = red;
            assign nv  = cv;
            assign nt  = ct;
        end
    end

    logic [P-1:0]     fin_sum;
    logic             fin_v;
    logic [TAG_W-1:0] fin_t;

    assign fin_sum = g_lvl[LEVELS-1].nxt[0] + g_lvl[LEVELS-1].nxt[1];
    assign fin_v   = g_lvl[LEVELS-1].nv;
    assign fin_t   = g_lvl[LEVELS-1].nt;

    // Data only loads on valid beats so bubbles never disturb the visible product
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= fin_v;
            if (fin_v) begin
                out_prod <= fin_sum;
                out_tag  <= fin_t;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Bench for wallace_mul_pipe: directed corners, back-pressure, mid-stream reset
// and two extra parameterisations checked against plain-arithmetic products.
module tb_wallace_mul_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_signed, out_ready, in_ready, out_valid;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [63:0] out_prod;

    wallace_mul_pipe #(.WIDTH(32), .LVL_PER_STG(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_tag(out_tag));

    logic        s8_v, s8_s, s8_rdy, o8_v;
    logic [7:0]  s8_a, s8_b;
    logic [1:0]  s8_t, o8_t;
    logic [15:0] o8_p;

    wallace_mul_pipe #(.WIDTH(8), .LVL_PER_STG(1), .TAG_W(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(s8_v), .in_ready(s8_rdy),
        .in_a(s8_a), .in_b(s8_b), .in_signed(s8_s), .in_tag(s8_t),
        .out_valid(o8_v), .out_ready(1'b1), .out_prod(o8_p), .out_tag(o8_t));

    logic        s16_v, s16_s, s16_rdy, o16_v;
    logic [15:0] s16_a, s16_b;
    logic [2:0]  s16_t, o16_t;
    logic [31:0] o16_p;

    wallace_mul_pipe #(.WIDTH(16), .LVL_PER_STG(6), .TAG_W(3)) u16 (
        .clk(clk), .rst(rst), .in_valid(s16_v), .in_ready(s16_rdy),
        .in_a(s16_a), .in_b(s16_b), .in_signed(s16_s), .in_tag(s16_t),
        .out_valid(o16_v), .out_ready(1'b1), .out_prod(o16_p), .out_tag(o16_t));

    localparam int LAT = 5;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [63:0] ref32(logic [31:0] a, logic [31:0] b, logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref16(logic [15:0] a, logic [15:0] b, logic s);
        logic [31:0] ea, eb;
        ea = s ? {{16{a[15]}}, a} : {16'b0, a};
        eb = s ? {{16{b[15]}}, b} : {16'b0, b};
        return ea * eb;
    endfunction

    // Drives one beat until accepted; called and returns 1ns after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [3:0] t);
        logic ok;
        int   w;
        exp_t e;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            w++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted after %0d cycles", w);
        end else begin
            e.p = ref32(a, b, s);
            e.t = t;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_chk++;
        if (out_prod !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_prod: got %h expected 0", out_prod);
        end
        n_chk++;
        if (out_tag !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_tag: got %h expected 0", out_tag);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_chk++;
        if (o8_v !== 1'b0 || o16_v !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sweep_valid: got %b%b expected 00", o8_v, o16_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        int lat;
        out_ready = 1'b1;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'hA);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL latency: got %0d expected %0d", lat, LAT);
        end
        n_chk++;
        if (out_prod !== 64'hFFFFFFFE00000001) begin
            n_fail++;
            $display("FAIL latency_prod: got %h expected fffffffe00000001", out_prod);
        end
        n_chk++;
        if (out_tag !== 4'hA) begin
            n_fail++;
            $display("FAIL latency_tag: got %h expected a", out_tag);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed_b2b;
        logic [63:0] ep [3];
        logic [3:0]  et [3];
        int w;
        ep[0] = 64'h0000000000000001;
        ep[1] = 64'hFFFFFFFF80000000;
        ep[2] = 64'h4000000000000000;
        et[0] = 4'h1;
        et[1] = 4'h2;
        et[2] = 4'h3;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'h1);
        send(32'h80000000, 32'h00000001, 1'b1, 4'h2);
        send(32'h80000000, 32'h80000000, 1'b1, 4'h3);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_chk++;
        if (w != LAT - 2) begin
            n_fail++;
            $display("FAIL b2b_first_latency: got %0d expected %0d", w, LAT - 2);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_prod !== ep[k]) begin
                n_fail++;
                $display("FAIL b2b_prod%0d: got v=%b %h expected v=1 %h",
                         k, out_valid, out_prod, ep[k]);
            end
            n_chk++;
            if (out_tag !== et[k]) begin
                n_fail++;
                $display("FAIL b2b_tag%0d: got %h expected %h", k, out_tag, et[k]);
            end
            @(posedge clk);
            #1;
        end
        exp_q.delete();
    endtask

    task automatic test_zero_identity;
        logic [63:0] ep [3];
        int w;
        ep[0] = 64'h0;
        ep[1] = 64'h12345678;
        ep[2] = 64'hFFFFFFFFFFFFFFF9;
        send(32'h0, 32'h12345678, 1'b0, 4'h4);
        send(32'h1, 32'h12345678, 1'b0, 4'h5);
        send(32'hFFFFFFFF, 32'h7, 1'b1, 4'h6);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_prod !== ep[k]) begin
                n_fail++;
                $display("FAIL zero_identity%0d: got v=%b %h expected v=1 %h",
                         k, out_valid, out_prod, ep[k]);
            end
            @(posedge clk);
            #1;
        end
        exp_q.delete();
    endtask

    task automatic test_back_pressure;
        int got;
        int cyc;
        logic        prev_stall;
        logic [63:0] prev_p;
        logic [3:0]  prev_t;
        exp_t        e;
        prev_stall = 1'b0;
        prev_p = '0;
        prev_t = '0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [31:0] a;
                    a = (i % 5 == 0) ? 32'h80000000 : $urandom;
                    send(a, $urandom, 1'($urandom), 4'($urandom));
                    if ($urandom_range(2, 0) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                got = 0;
                cyc = 0;
                while (got < 20 && cyc < 1000) begin
                    @(negedge clk);
                    n_chk++;
                    if (in_ready !== !(out_valid && !out_ready)) begin
                        n_fail++;
                        $display("FAIL bp_in_ready: got %b with v=%b r=%b",
                                 in_ready, out_valid, out_ready);
                    end
                    if (prev_stall) begin
                        n_chk++;
                        if (out_valid !== 1'b1 || out_prod !== prev_p ||
                            out_tag !== prev_t) begin
                            n_fail++;
                            $display("FAIL bp_stable: got v=%b %h/%h expected v=1 %h/%h",
                                     out_valid, out_prod, out_tag, prev_p, prev_t);
                        end
                    end
                    if (out_valid && out_ready) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL bp_extra: got %h expected none", out_prod);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_prod !== e.p || out_tag !== e.t) begin
                                n_fail++;
                                $display("FAIL bp_prod: got %h/%h expected %h/%h",
                                         out_prod, out_tag, e.p, e.t);
                            end
                        end
                        got++;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_p = out_prod;
                    prev_t = out_tag;
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                    cyc++;
                end
                n_chk++;
                if (got != 20) begin
                    n_fail++;
                    $display("FAIL bp_count: got %0d expected 20", got);
                end
            end
        join
        out_ready = 1'b1;
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream;
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom), 4'(i));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0 || out_prod !== 64'h0) begin
                n_fail++;
                $display("FAIL rst_mid%0d: got v=%b %h expected v=0 0",
                         k, out_valid, out_prod);
            end
        end
        @(posedge clk);
        #1;
        send(32'd3, 32'd5, 1'b0, 4'h9);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_chk++;
        if (w != LAT || out_prod !== 64'd15 || out_tag !== 4'h9) begin
            n_fail++;
            $display("FAIL rst_recover: got lat=%0d %h/%h expected lat=%0d f/9",
                     w, out_prod, out_tag, LAT);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep;
        localparam int NB = 4000;
        logic [17:0] q8[$];
        logic [34:0] q16[$];
        int c8, c16, cyc;
        logic [17:0] e8;
        logic [34:0] e16;
        c8 = 0;
        c16 = 0;
        fork
            begin
                for (int i = 0; i < NB; i++) begin
                    s8_a  = 8'(i);
                    s8_b  = (i < 256) ? 8'h80 : (i < 512) ? 8'hFF : 8'($urandom);
                    s8_s  = (i < 512) ? 1'(i >> 8) ^ 1'(i) : 1'($urandom);
                    s8_t  = 2'($urandom);
                    s8_v  = 1'b1;
                    s16_a = (i < 16) ? 16'h8000 : 16'($urandom);
                    s16_b = (i < 16) ? 16'(i * 4099) : 16'($urandom);
                    s16_s = 1'($urandom);
                    s16_t = 3'($urandom);
                    s16_v = 1'b1;
                    q8.push_back({ref8(s8_a, s8_b, s8_s), s8_t});
                    q16.push_back({ref16(s16_a, s16_b, s16_s), s16_t});
                    @(posedge clk);
                    #1;
                end
                s8_v  = 1'b0;
                s16_v = 1'b0;
            end
            begin
                cyc = 0;
                while ((c8 < NB || c16 < NB) && cyc < NB + 60) begin
                    @(negedge clk);
                    if (o8_v) begin
                        n_chk++;
                        e8 = (q8.size() > 0) ? q8.pop_front() : 18'h0;
                        if ({o8_p, o8_t} !== e8) begin
                            n_fail++;
                            $display("FAIL sweep8: got %h/%h expected %h/%h",
                                     o8_p, o8_t, e8[17:2], e8[1:0]);
                        end
                        c8++;
                    end
                    if (o16_v) begin
                        n_chk++;
                        e16 = (q16.size() > 0) ? q16.pop_front() : 35'h0;
                        if ({o16_p, o16_t} !== e16) begin
                            n_fail++;
                            $display("FAIL sweep16: got %h/%h expected %h/%h",
                                     o16_p, o16_t, e16[34:3], e16[2:0]);
                        end
                        c16++;
                    end
                    cyc++;
                end
                n_chk++;
                if (c8 != NB || c16 != NB) begin
                    n_fail++;
                    $display("FAIL sweep_count: got %0d/%0d expected %0d", c8, c16, NB);
                end
            end
        join
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_signed = 1'b0;
        in_tag = '0;
        out_ready = 1'b1;
        s8_v = 1'b0; s8_s = 1'b0; s8_a = '0; s8_b = '0; s8_t = '0;
        s16_v = 1'b0; s16_s = 1'b0; s16_a = '0; s16_b = '0; s16_t = '0;
        test_reset;
        test_latency;
        test_signed_b2b;
        test_zero_identity;
        test_back_pressure;
        test_reset_midstream;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
